// File: rtl/snn_pkg.sv
// Shared types, defaults and helpers for the SNN frame loader slice.
package snn_pkg;

    localparam int unsigned SNN_WORD_W     = 32;
    localparam int unsigned SNN_FRAME_BITS = 800;
    localparam int unsigned SNN_RES_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        RUN,
        DONE
    } loader_state_t;

    // Number of mailbox words needed to carry one frame (rounded up).
    function automatic int unsigned snn_nwords(input int unsigned frame_bits,
                                               input int unsigned word_w);
        return (frame_bits + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/snn_word_watchdog.sv
// Inter-word idle counter: flags the cycle on which LIMIT consecutive idle cycles complete.
module snn_word_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iACTIVE,
    input  logic iKICK,
    output logic oEXPIRE_c
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] idleCnt;

    always_ff @(posedge iCLK) begin
        if (iRESET || !iACTIVE || iKICK) begin
            idleCnt <= '0;
        end else if (idleCnt != LAST_CNT) begin
            idleCnt <= CNT_W'(idleCnt + 1'b1);
        end
    end

    assign oEXPIRE_c = iACTIVE && !iKICK && (idleCnt == LAST_CNT);

endmodule

// File: rtl/snn_frame_loader.sv
// Assembles mailbox words into a frame, fires the network, and latches its result.
// Optional inter-word watchdog: define SNN_FRAME_LOADER_TIMEOUT_EN.
module snn_frame_loader
    import snn_pkg::*;
#(
    parameter int unsigned WORD_W         = SNN_WORD_W,
    parameter int unsigned FRAME_BITS     = SNN_FRAME_BITS,
    parameter int unsigned RES_W          = SNN_RES_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  iWR_VALID,
    input  logic [WORD_W-1:0]     iWR_DATA,
    output logic                  oWR_READY,
    input  logic                  iCLEAR,
    output logic [FRAME_BITS-1:0] oFRAME,
    output logic                  oSTART,
    input  logic                  iSNN_DONE,
    input  logic [RES_W-1:0]      iSNN_RESULT,
    output logic [RES_W-1:0]      oRESULT,
    output logic                  oRESULT_VALID,
    output logic                  oBUSY,
    output logic                  oERROR
);

    localparam int unsigned NWORDS = snn_nwords(FRAME_BITS, WORD_W);
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BUF_W  = NWORDS * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] FIRST_NXT = (NWORDS == 1) ? '0 : IDX_W'(1);

    loader_state_t    state, stateNext;
    logic [IDX_W-1:0] wordIdx, idxNext, wrIdx;
    logic             accept;
    logic             timeout;
    logic             resultLatch;
    logic [BUF_W-1:0] bufNext;

    assign oWR_READY = (state == IDLE) || (state == LOAD) || (state == DONE);
    assign accept    = iWR_VALID && oWR_READY && !iCLEAR;

`ifdef SNN_FRAME_LOADER_TIMEOUT_EN
    logic expire;

    snn_word_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uWatchdog (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iACTIVE  (state == LOAD),
        .iKICK    (accept),
        .oEXPIRE_c(expire)
    );

    assign timeout = expire && !iCLEAR;

    // Sticky abort flag, cleared only by the next accepted first word.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oERROR <= 1'b0;
        end else if (accept && (state != LOAD)) begin
            oERROR <= 1'b0;
        end else if (timeout) begin
            oERROR <= 1'b1;
        end
    end
`else
    logic unusedTimeout;

    assign unusedTimeout = |32'(TIMEOUT_CYCLES);
    assign timeout       = 1'b0;
    assign oERROR        = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state   <= IDLE;
            wordIdx <= '0;
        end else begin
            state   <= stateNext;
            wordIdx <= idxNext;
        end
    end

    always_comb begin
        stateNext   = state;
        idxNext     = wordIdx;
        wrIdx       = '0;
        resultLatch = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    idxNext   = FIRST_NXT;
                    stateNext = (NWORDS == 1) ? FIRE : LOAD;
                end
            end
            LOAD: begin
                wrIdx = wordIdx;
                if (accept) begin
                    if (wordIdx == LAST_IDX) begin
                        idxNext   = '0;
                        stateNext = FIRE;
                    end else begin
                        idxNext = IDX_W'(wordIdx + 1'b1);
                    end
                end else if (timeout) begin
                    idxNext   = '0;
                    stateNext = IDLE;
                end
            end
            FIRE: stateNext = RUN;
            RUN: begin
                if (iSNN_DONE) begin
                    resultLatch = 1'b1;
                    stateNext   = DONE;
                end
            end
            default: begin
                idxNext   = '0;
                stateNext = IDLE;
            end
        endcase
        // Clear wins over any same-cycle handshake or completion.
        if (iCLEAR) begin
            stateNext   = IDLE;
            idxNext     = '0;
            resultLatch = 1'b0;
        end
    end

    // Padded view so the last word's excess bits fall off the top.
    always_comb begin
        bufNext                           = BUF_W'(oFRAME);
        bufNext[wrIdx*WORD_W +: WORD_W]   = iWR_DATA;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oFRAME        <= '0;
            oRESULT       <= '0;
            oRESULT_VALID <= 1'b0;
            oSTART        <= 1'b0;
            oBUSY         <= 1'b0;
        end else begin
            oSTART <= (stateNext == FIRE);
            oBUSY  <= (stateNext != IDLE);
            if (accept) begin
                oFRAME <= FRAME_BITS'(bufNext);
            end
            if (resultLatch) begin
                oRESULT <= iSNN_RESULT;
            end
            if (iCLEAR || (accept && (state != LOAD))) begin
                oRESULT_VALID <= 1'b0;
            end else if (resultLatch) begin
                oRESULT_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed bench for snn_frame_loader; expectations are hand-computed constants.
module tb_snn_frame_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wrValid = 1'b0;
    logic [31:0]  wrData = '0;
    logic         wrReady;
    logic         clr = 1'b0;
    logic [799:0] frame;
    logic         start;
    logic         snnDone = 1'b0;
    logic [1:0]   snnResult = '0;
    logic [1:0]   result;
    logic         resultValid;
    logic         busy;
    logic         err;

    int passCnt  = 0;
    int totalCnt = 0;

    snn_frame_loader #(
        .WORD_W(32),
        .FRAME_BITS(800),
        .RES_W(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .iCLK         (clk),
        .iRESET       (rst),
        .iWR_VALID    (wrValid),
        .iWR_DATA     (wrData),
        .oWR_READY    (wrReady),
        .iCLEAR       (clr),
        .oFRAME       (frame),
        .oSTART       (start),
        .iSNN_DONE    (snnDone),
        .iSNN_RESULT  (snnResult),
        .oRESULT      (result),
        .oRESULT_VALID(resultValid),
        .oBUSY        (busy),
        .oERROR       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] frameWord(input int k);
        return frame[32*k +: 32];
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_frame_w0", frameWord(0), 32'h0);
        chk("rst_frame_w24", frameWord(24), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_valid", 32'(resultValid), 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ready", 32'(wrReady), 32'h1);

        // Frame 1: word k = k, valid held high
        for (int k = 0; k < 25; k++) begin
            chk("f1_ready", 32'(wrReady), 32'h1);
            wrValid = 1'b1;
            wrData  = 32'(k);
            tick();
            chk("f1_busy", 32'(busy), 32'h1);
            if (k < 24) chk("f1_start_early", 32'(start), 32'h0);
        end
        wrValid = 1'b0;
        chk("f1_start", 32'(start), 32'h1);
        chk("f1_ready_fire", 32'(wrReady), 32'h0);
        for (int k = 0; k < 25; k++) chk("f1_frame", frameWord(k), 32'(k));
        tick();
        chk("f1_start_one", 32'(start), 32'h0);
        chk("f1_busy_run", 32'(busy), 32'h1);
        tick();
        snnDone   = 1'b1;
        snnResult = 2'd2;
        tick();
        chk("f1_result", 32'(result), 32'h2);
        chk("f1_valid", 32'(resultValid), 32'h1);
        chk("f1_ready_done", 32'(wrReady), 32'h1);
        snnResult = 2'd1;
        tick();
        chk("f1_second_done", 32'(result), 32'h2);
        chk("f1_valid_hold", 32'(resultValid), 32'h1);
        snnDone = 1'b0;

        // Frame 2a from DONE, aborted by clear on word 10
        for (int k = 0; k < 10; k++) begin
            wrValid = 1'b1;
            wrData  = 32'h200 + 32'(k);
            tick();
        end
        chk("f2_valid_fell", 32'(resultValid), 32'h0);
        wrData = 32'hDEADBEEF;
        clr    = 1'b1;
        tick();
        clr     = 1'b0;
        wrValid = 1'b0;
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_ready", 32'(wrReady), 32'h1);
        chk("clr_result_kept", 32'(result), 32'h2);
        chk("clr_w10_dropped", frameWord(10), 32'h0000000A);
        chk("clr_w9_kept", frameWord(9), 32'h209);
        tick();
        chk("clr_idle_stays", 32'(busy), 32'h0);

        // Frame 2b restarts at index 0
        for (int k = 0; k < 25; k++) begin
            wrValid = 1'b1;
            wrData  = 32'h300 + 32'(k);
            tick();
            if (k == 0) chk("f2b_w0_idx0", frameWord(0), 32'h300);
            if (k == 0) chk("f2b_w1_untouched", frameWord(1), 32'h201);
        end
        wrValid = 1'b0;
        chk("f2b_start", 32'(start), 32'h1);
        chk("f2b_w10", frameWord(10), 32'h30A);
        chk("f2b_w24", frameWord(24), 32'h318);
        // Done during FIRE is ignored
        snnDone   = 1'b1;
        snnResult = 2'd3;
        tick();
        chk("fire_done_ignored", 32'(resultValid), 32'h0);
        chk("fire_result_kept", 32'(result), 32'h2);
        snnResult = 2'd1;
        tick();
        chk("f2b_result", 32'(result), 32'h1);
        chk("f2b_valid", 32'(resultValid), 32'h1);
        snnDone = 1'b0;

        // Back-to-back: frame 3 word 0 in first DONE cycle
        for (int k = 0; k < 25; k++) begin
            wrValid = 1'b1;
            wrData  = 32'hCAFE0000 + 32'(k);
            tick();
            if (k == 0) chk("b2b_valid_fell", 32'(resultValid), 32'h0);
            if (k == 0) chk("b2b_w0", frameWord(0), 32'hCAFE0000);
        end
        wrValid = 1'b0;
        chk("b2b_start", 32'(start), 32'h1);
        tick();
        chk("b2b_run_busy", 32'(busy), 32'h1);

        // Reset during RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrun_frame", frameWord(0), 32'h0);
        chk("rrun_result", 32'(result), 32'h0);
        chk("rrun_valid", 32'(resultValid), 32'h0);
        chk("rrun_busy", 32'(busy), 32'h0);
        chk("rrun_start", 32'(start), 32'h0);
        chk("rrun_ready", 32'(wrReady), 32'h1);
        snnDone   = 1'b1;
        snnResult = 2'd3;
        tick();
        snnDone = 1'b0;
        chk("rrun_late_done_valid", 32'(resultValid), 32'h0);
        chk("rrun_late_done_result", 32'(result), 32'h0);

        // Stall after word 5
        for (int k = 0; k < 6; k++) begin
            wrValid = 1'b1;
            wrData  = 32'h500 + 32'(k);
            tick();
        end
        wrValid = 1'b0;
        for (int c = 0; c < 15; c++) tick();
        chk("stall15_busy", 32'(busy), 32'h1);
        chk("stall15_err", 32'(err), 32'h0);
        tick();
`ifdef SNN_FRAME_LOADER_TIMEOUT_EN
        chk("wd_err", 32'(err), 32'h1);
        chk("wd_busy", 32'(busy), 32'h0);
        wrValid = 1'b1;
        wrData  = 32'h600;
        tick();
        wrValid = 1'b0;
        chk("wd_err_cleared", 32'(err), 32'h0);
        chk("wd_new_w0", frameWord(0), 32'h600);
        chk("wd_new_busy", 32'(busy), 32'h1);
`else
        chk("stall16_err", 32'(err), 32'h0);
        chk("stall16_busy", 32'(busy), 32'h1);
        for (int c = 0; c < 10; c++) tick();
        for (int k = 6; k < 25; k++) begin
            wrValid = 1'b1;
            wrData  = 32'h500 + 32'(k);
            tick();
        end
        wrValid = 1'b0;
        chk("stall_resume_start", 32'(start), 32'h1);
        chk("stall_w5", frameWord(5), 32'h505);
        chk("stall_w6", frameWord(6), 32'h506);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
